// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, packet-aware arbiter sharing one fifo write port with credit tracking.
// Optional credit checking via FIFO_WR_ARBITER_CREDIT_CHK_EN.  Rev 1.0
`default_nettype none

module fifo_wr_arbiter #(
    parameter int N_SRC  = 4,
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 4
) (
    input  logic                      clk_i,
    input  logic                      arst_i,
    input  logic [N_SRC-1:0]          req_i,
    input  logic [N_SRC*DWIDTH-1:0]   data_i,
    input  logic [N_SRC-1:0]          last_i,
    output logic [N_SRC-1:0]          ack_o,
    output logic                      fifo_wrreq_o,
    output logic [DWIDTH-1:0]         fifo_data_o,
    input  logic                      fifo_rdreq_i,
    output logic [AWIDTH:0]           occupancy_o,
    output logic [N_SRC-1:0]          grant_o,
    output logic                      err_o
);

    localparam int              IW         = $clog2(N_SRC);
    localparam logic [AWIDTH:0] c_DEPTH    = {1'b1, {AWIDTH{1'b0}}};
    localparam logic [IW-1:0]   c_LAST_SRC = IW'(N_SRC - 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [IW-1:0]      r_rr, w_rr_nxt;
    logic [IW-1:0]      r_lock, w_lock_nxt;
    logic [N_SRC-1:0]   r_grant, w_grant_nxt;
    logic [AWIDTH:0]    r_occ;
    logic               r_wrreq;
    logic [DWIDTH-1:0]  r_data;

    logic               w_space;
    logic               w_found;
    logic [IW-1:0]      w_idx;
    logic [IW-1:0]      w_idx_inc;
    logic               w_accept;
    logic               w_acc_last;
    logic [DWIDTH-1:0]  w_acc_data;

    assign w_space = (r_occ < c_DEPTH);

    // Candidate source: the locked one, or first requester from the rr pointer upward.
    always_comb begin : p_scan
        int            j;
        logic [IW-1:0] w_cand;
        j       = 0;
        w_cand  = '0;
        w_found = 1'b0;
        w_idx   = '0;
        if (r_state == ST_LOCKED) begin
            w_found = req_i[r_lock];
            w_idx   = r_lock;
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                j = int'(r_rr) + i;
                if (j >= N_SRC) begin
                    j = j - N_SRC;
                end
                w_cand = IW'(j);
                if (!w_found && req_i[w_cand]) begin
                    w_found = 1'b1;
                    w_idx   = w_cand;
                end
            end
        end
    end

    always_comb begin
        w_acc_data = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (IW'(k) == w_idx) begin
                w_acc_data = data_i[k*DWIDTH +: DWIDTH];
            end
        end
    end

    assign w_acc_last = last_i[w_idx];
    assign w_accept   = w_found && w_space && !arst_i;
    assign w_idx_inc  = (w_idx == c_LAST_SRC) ? '0 : w_idx + 1'b1;

    always_comb begin
        ack_o = '0;
        if (w_accept) begin
            ack_o[w_idx] = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr;
        w_lock_nxt  = r_lock;
        w_grant_nxt = r_grant;
        if (w_accept && w_acc_last) begin
            w_state_nxt = ST_IDLE;
            w_rr_nxt    = w_idx_inc;
            w_grant_nxt = '0;
        end else if (w_accept && (r_state == ST_IDLE)) begin
            w_state_nxt        = ST_LOCKED;
            w_lock_nxt         = w_idx;
            w_grant_nxt        = '0;
            w_grant_nxt[w_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state <= ST_IDLE;
            r_rr    <= '0;
            r_lock  <= '0;
            r_grant <= '0;
            r_occ   <= '0;
            r_wrreq <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rr    <= w_rr_nxt;
            r_lock  <= w_lock_nxt;
            r_grant <= w_grant_nxt;
            r_wrreq <= w_accept;
            if (w_accept) begin
                r_data <= w_acc_data;
            end
            // Credit taken at ack time; a simultaneous read cancels it out.
            case ({w_accept, fifo_rdreq_i})
                2'b10:   if (r_occ != c_DEPTH) r_occ <= r_occ + 1'b1;
                2'b01:   if (r_occ != '0)      r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

`ifdef FIFO_WR_ARBITER_CREDIT_CHK_EN
    logic r_err;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_err <= 1'b0;
        end else if ((fifo_rdreq_i && (r_occ == '0)) || (w_accept && (r_occ == c_DEPTH))) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;
`else
    assign err_o = 1'b0;
`endif

    assign fifo_wrreq_o = r_wrreq;
    assign fifo_data_o  = r_data;
    assign occupancy_o  = r_occ;
    assign grant_o      = r_grant;

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: randomized and directed stimulus against a behavioural arbiter/credit model.
`default_nettype none

module tb_fifo_wr_arbiter;

    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic                   clk = 1'b0;
    logic                   arst;
    logic [N-1:0]           req, last, ack, grant;
    logic [N-1:0][DW-1:0]   data;
    logic                   rdreq, wrreq, err;
    logic [DW-1:0]          fdata;
    logic [AW:0]            occ;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.N_SRC(N), .DWIDTH(DW), .AWIDTH(AW)) dut (
        .clk_i        (clk),
        .arst_i       (arst),
        .req_i        (req),
        .data_i       (data),
        .last_i       (last),
        .ack_o        (ack),
        .fifo_wrreq_o (wrreq),
        .fifo_data_o  (fdata),
        .fifo_rdreq_i (rdreq),
        .occupancy_o  (occ),
        .grant_o      (grant),
        .err_o        (err)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit          m_locked;
    int          m_lock, m_rr, m_occ, m_acc;
    bit          m_wrreq, m_err;
    logic [DW-1:0] m_data;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_locked = 0; m_lock = 0; m_rr = 0; m_occ = 0; m_acc = -1;
        m_wrreq = 0; m_err = 0; m_data = '0;
    endtask

    function automatic int pick();
        if (m_occ >= DEPTH) return -1;
        if (m_locked) return req[m_lock] ? m_lock : -1;
        for (int i = 0; i < N; i++) begin
            if (req[(m_rr + i) % N]) return (m_rr + i) % N;
        end
        return -1;
    endfunction

    task automatic check_outputs();
        logic [N-1:0] ea, eg;
        ea = '0;
        eg = '0;
        if (m_acc >= 0) ea[m_acc] = 1'b1;
        if (m_locked)   eg[m_lock] = 1'b1;
        check("ack",   32'(ack),   32'(ea));
        check("grant", 32'(grant), 32'(eg));
        check("occ",   32'(occ),   32'(m_occ));
        check("wrreq", 32'(wrreq), 32'(m_wrreq));
        check("fdata", 32'(fdata), 32'(m_data));
        check("err",   32'(err),   32'(m_err));
    endtask

    // One clock: check at negedge, then advance the model at posedge.
    task automatic cycle();
        @(negedge clk);
        m_acc = pick();
        check_outputs();
        @(posedge clk);
`ifdef FIFO_WR_ARBITER_CREDIT_CHK_EN
        if (rdreq && m_occ == 0) m_err = 1;
`endif
        if (m_acc >= 0 && !rdreq) begin
            if (m_occ < DEPTH) m_occ++;
        end else if (m_acc < 0 && rdreq && m_occ > 0) begin
            m_occ--;
        end
        m_wrreq = (m_acc >= 0);
        if (m_acc >= 0) begin
            m_data = data[m_acc];
            if (last[m_acc]) begin
                m_locked = 0;
                m_rr     = (m_acc + 1) % N;
            end else begin
                m_locked = 1;
                m_lock   = m_acc;
            end
        end
        #1;
    endtask

    task automatic release_reset();
        req   = '0;
        rdreq = 1'b0;
        @(negedge clk);
        arst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req  = '0;
        arst = 1'b1;
        #3;
        release_reset();
    endtask

    // Producers obey the hold-until-ack rule; only acked or idle sources change.
    task automatic produce(input int req_pct, input int last_pct);
        for (int k = 0; k < N; k++) begin
            if (!req[k] || m_acc == k) begin
                req[k]  = ($urandom_range(0, 99) < req_pct);
                data[k] = DW'($urandom);
                last[k] = ($urandom_range(0, 99) < last_pct);
            end
        end
    endtask

    initial begin
        arst  = 1'b1;
        req   = '0;
        last  = '0;
        data  = '0;
        rdreq = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        req  = '1;
        last = '1;
        #1;
        check("rst_ack",   32'(ack),   32'd0);
        check("rst_wrreq", 32'(wrreq), 32'd0);
        check("rst_occ",   32'(occ),   32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_fdata", 32'(fdata), 32'd0);
        check("rst_err",   32'(err),   32'd0);
        release_reset();

        // Single-beat fairness until full
        req  = '1;
        last = '1;
        for (int k = 0; k < N; k++) data[k] = DW'($urandom);
        for (int c = 0; c < 20; c++) begin
            cycle();
            if (m_acc >= 0) data[m_acc] = DW'($urandom);
        end
        check("fair_full", 32'(occ), 32'd16);

        // Full back-pressure: single read pulse frees one credit for the next cycle
        req   = 4'b0001;
        rdreq = 1'b1;
        cycle();
        rdreq = 1'b0;
        repeat (2) cycle();
        check("bp_refill", 32'(occ), 32'd16);

        req   = '0;
        rdreq = 1'b1;
        repeat (DEPTH) cycle();
        rdreq = 1'b0;

        // Packet lock: src1 three beats while src2 waits
        do_reset();
        req  = 4'b0110;
        last = 4'b0100;
        data[1] = 8'h11;
        data[2] = 8'h22;
        cycle();
        data[1] = 8'h12;
        cycle();
        data[1] = 8'h13;
        last[1] = 1'b1;
        cycle();
        req[1] = 1'b0;
        cycle();
        req = '0;
        repeat (2) cycle();

        // Simultaneous write and read at occupancy 8
        do_reset();
        req  = 4'b0001;
        last = '1;
        for (int c = 0; c < 32 && m_occ < 8; c++) begin
            data[0] = DW'($urandom);
            cycle();
        end
        data[0] = 8'hA5;
        rdreq   = 1'b1;
        cycle();
        req   = '0;
        rdreq = 1'b0;
        cycle();
        check("wr_rd_occ", 32'(occ), 32'd8);

        // Randomized traffic with random reads
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            produce(60, 40);
            rdreq = ($urandom_range(0, 99) < ((c / 300) % 2 == 0 ? 30 : 70));
            cycle();
        end
        rdreq = 1'b0;

        // Async reset mid-packet
        do_reset();
        req  = 4'b1000;
        last = '0;
        repeat (2) begin
            data[3] = DW'($urandom);
            cycle();
        end
        check("lock_grant3", 32'(grant), 32'b1000);
        #3;
        arst = 1'b1;
        #1;
        check("arst_ack",   32'(ack),   32'd0);
        check("arst_grant", 32'(grant), 32'd0);
        check("arst_occ",   32'(occ),   32'd0);
        check("arst_wrreq", 32'(wrreq), 32'd0);
        check("arst_fdata", 32'(fdata), 32'd0);
        release_reset();
        req  = 4'b1001;
        last = 4'b1001;
        cycle();
        req = '0;
        cycle();

        // Underflow read: sticky err only when credit checking is compiled in
        do_reset();
        rdreq = 1'b1;
        cycle();
        rdreq = 1'b0;
        repeat (3) cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin, packet-aware write arbiter that shares one fifo write port (wrreq/data) between N_SRC requesters.
- Tracks fifo occupancy with its own credit counter and never issues a write into a full fifo.
- Sits between N producer blocks and a single fifo instance. Its registered outputs drive the fifo directly.

Parameters:
- N_SRC, 4, number of requesters (2..16)
- DWIDTH, 8, data width, must match the fifo
- AWIDTH, 4, fifo address width; fifo depth DEPTH = 2**AWIDTH

Ports:
- clk_i  in  1  clock
- arst_i  in  1  asynchronous active-high reset
- req_i  in  N_SRC  per-source write request; held with data until ack
- data_i  in  N_SRC*DWIDTH  per-source data, source k at bits [k*DWIDTH +: DWIDTH]
- last_i  in  N_SRC  per-source end-of-packet marker, qualified by req_i
- ack_o  out  N_SRC  combinational one-hot accept; beat transfers when req_i[k] && ack_o[k]
- fifo_wrreq_o  out  1  registered write strobe to fifo wrreq_i
- fifo_data_o  out  DWIDTH  registered write data to fifo data_i
- fifo_rdreq_i  in  1  copy of the fifo's rdreq_i, used to return credit
- occupancy_o  out  AWIDTH+1  credit-counter value, 0..DEPTH
- grant_o  out  N_SRC  one-hot current/locked grant, registered
- err_o  out  1  sticky credit error, see Optional Feature

Behaviour:
- Reset (arst_i=1, asynchronous):
  - fifo_wrreq_o=0, fifo_data_o=0, occupancy_o=0, grant_o=0, err_o=0
  - state=IDLE, rr pointer=0
  - ack_o=0 while reset is asserted
- space = (occupancy_o < DEPTH).
- State IDLE:
  - Pick the first k with req_i[k]=1, scanning from the rr pointer upward modulo N_SRC.
  - If space is available, ack_o[k]=1 in the same cycle.
  - If the accepted beat has last_i[k]=0: go to LOCKED, set grant_o to one-hot k.
  - If the accepted beat has last_i[k]=1: stay IDLE, set rr pointer to (k+1) mod N_SRC.
  - No req_i, or no space: ack_o=0, no state change.
- State LOCKED(k):
  - Only source k can be acked, and only when req_i[k] and space are both true. Other requests wait.
  - A source-k beat accepted with last_i[k]=1: go to IDLE, rr pointer=(k+1) mod N_SRC, grant_o=0.
  - req_i[k] low while LOCKED: stay LOCKED, no timeout.
- Write pipeline:
  - On an accepted beat, the next cycle gives fifo_wrreq_o=1 and fifo_data_o = the accepted data.
  - Otherwise fifo_wrreq_o=0 and fifo_data_o holds its value.
  - Latency from ack to fifo write is 1 cycle. At most one beat per cycle. Sustained throughput is 1 beat/clk.
- Credit counter:
  - +1 on an accepted beat (counted at ack time, not at fifo_wrreq_o).
  - -1 on fifo_rdreq_i.
  - Both in the same cycle: unchanged.
  - Saturates at 0 and DEPTH; never wraps.
- Boundaries:
  - occupancy_o==DEPTH: no ack. Simultaneous fifo_rdreq_i does not enable an ack in that cycle; the freed credit is usable next cycle.
  - rr pointer wraps N_SRC-1 -> 0.
  - Reset mid-packet drops the lock. The source must restart its packet.

Optional Feature:
- Macro: FIFO_WR_ARBITER_CREDIT_CHK_EN.
- Defined:
  - err_o is set and held until reset when fifo_rdreq_i=1 while occupancy_o==0 (underflow).
  - err_o is also set on an attempted increment while occupancy_o==DEPTH (cannot happen in correct RTL; assertion aid).
- Undefined: err_o is tied 0 and the checking logic is not compiled.

Test Plan:
- Single-beat fairness: req_i=4'b1111, all last_i=1, no reads. ack order is src0,1,2,3,0,... one per cycle. fifo_wrreq_o stays high from cycle 1. occupancy_o reaches 16, then ack stops.
- Packet lock: src1 sends 3 beats (last on the 3rd) while src2 requests. All 3 src1 beats are acked consecutively before src2. grant_o=4'b0010 during the packet. src2 is acked the cycle after src1's last beat.
- Full back-pressure: fill to occupancy_o=16, hold req_i[0]=1, pulse fifo_rdreq_i once. No ack in the pulse cycle. One ack the next cycle. occupancy_o reads 16 -> 15 -> 16.
- Simultaneous write and read at occupancy_o=8: ack and fifo_rdreq_i in the same cycle leave occupancy_o=8. fifo_data_o equals the acked source's data one cycle later.
- Async reset mid-packet: src3 LOCKED after 2 beats, assert arst_i mid-cycle. Outputs go to 0 immediately. After release, src0 request (rr pointer=0) is acked first.
- With FIFO_WR_ARBITER_CREDIT_CHK_EN: fifo_rdreq_i=1 at occupancy_o=0 gives err_o=1 the next cycle, held until reset. Without the macro, err_o stays 0.
